// File: rtl/butterfly_pair_feeder.sv
// Ping-pong frame buffer feeding a radix-2 butterfly: frames arrive in natural
// order and leave as operand pairs x[k], x[k+N/2] with valid/ready on both sides.
module butterfly_pair_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int FFT_SIZE   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  validIn,
    output logic                  readyOut,
    input  logic [DATA_WIDTH-1:0] dataReIn,
    input  logic [DATA_WIDTH-1:0] dataImIn,
    output logic                  validOut,
    input  logic                  readyIn,
    output logic [DATA_WIDTH-1:0] dataReOut,
    output logic [DATA_WIDTH-1:0] dataImOut,
    output logic                  pairSelOut,
    output logic                  lastOut
);

    localparam int IW = $clog2(FFT_SIZE);
    localparam int SW = 2 * DATA_WIDTH;
    localparam logic [IW-1:0] LAST_IDX = IW'(FFT_SIZE - 1);

    logic [SW-1:0] mem [2][FFT_SIZE];
    logic [1:0]    full;
    logic          wr_bank;
    logic          rd_bank;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] rd_addr;
    logic          accept;
    logic          wr_done;
    logic          load;
    logic          rd_done;

    assign readyOut = !full[wr_bank] && !rst;
    assign accept   = validIn && readyOut;
    assign wr_done  = accept && (wr_idx == LAST_IDX);
    assign load     = (!validOut || readyIn) && full[rd_bank];
    assign rd_done  = load && (rd_idx == LAST_IDX);

    // Even read indices walk the lower half, odd ones the upper half.
    assign rd_addr = {rd_idx[0], rd_idx[IW-1:1]};

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_bank][wr_idx] <= {dataReIn, dataImIn};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank <= 1'b0;
            wr_idx  <= '0;
        end else if (accept) begin
            wr_idx <= wr_idx + 1'b1;
            if (wr_done)
                wr_bank <= ~wr_bank;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_bank <= 1'b0;
            rd_idx  <= '0;
        end else if (load) begin
            rd_idx <= rd_idx + 1'b1;
            if (rd_done)
                rd_bank <= ~rd_bank;
        end
    end

    // Writer and reader always sit on different banks when they complete,
    // so a set and a clear in the same cycle never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (wr_done && (wr_bank == b[0]))
                    full[b] <= 1'b1;
                else if (rd_done && (rd_bank == b[0]))
                    full[b] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            validOut   <= 1'b0;
            dataReOut  <= '0;
            dataImOut  <= '0;
            pairSelOut <= 1'b0;
            lastOut    <= 1'b0;
        end else if (load) begin
            validOut               <= 1'b1;
            {dataReOut, dataImOut} <= mem[rd_bank][rd_addr];
            pairSelOut             <= rd_idx[0];
            lastOut                <= (rd_idx == LAST_IDX);
        end else if (readyIn) begin
            validOut <= 1'b0;
        end
    end

endmodule

// File: tb/tb_butterfly_pair_feeder.sv
// Scoreboard bench for butterfly_pair_feeder: the driver queues the reordered
// frame once its last sample is accepted, the monitor pops on every output transfer.
module tb_butterfly_pair_feeder;

    localparam int DW = 16;
    localparam int N  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          validIn;
    logic          readyOut;
    logic [DW-1:0] dataReIn;
    logic [DW-1:0] dataImIn;
    logic          validOut;
    logic          readyIn;
    logic [DW-1:0] dataReOut;
    logic [DW-1:0] dataImOut;
    logic          pairSelOut;
    logic          lastOut;

    butterfly_pair_feeder #(.DATA_WIDTH(DW), .FFT_SIZE(N)) dut (
        .clk(clk), .rst(rst),
        .validIn(validIn), .readyOut(readyOut),
        .dataReIn(dataReIn), .dataImIn(dataImIn),
        .validOut(validOut), .readyIn(readyIn),
        .dataReOut(dataReOut), .dataImOut(dataImOut),
        .pairSelOut(pairSelOut), .lastOut(lastOut)
    );

    always #5 clk = ~clk;

    // Hand-derived emission order for N=8: x0,x4,x1,x5,x2,x6,x3,x7.
    int ORDER [N] = '{0, 4, 1, 5, 2, 6, 3, 7};

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int stalls   = 0;
    int nacc     = 0;
    logic          rnd_rdy = 1'b0;
    logic [DW-1:0] cur_re [N];
    logic [DW-1:0] cur_im [N];
    logic [2*DW+1:0] exp_q [$];
    int out_cyc [$];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im);
        int w;
        w = 0;
        validIn  = 1'b1;
        dataReIn = re;
        dataImIn = im;
        @(negedge clk);
        while (!readyOut && w < 500) begin
            w++;
            @(negedge clk);
        end
        if (w >= 500) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got readyOut=0 for %0d cycles expected accept", w);
            validIn = 1'b0;
            return;
        end
        stalls += w;
        @(posedge clk);
        #1;
        cur_re[nacc] = re;
        cur_im[nacc] = im;
        nacc++;
        if (nacc == N) begin
            for (int i = 0; i < N; i++)
                exp_q.push_back({cur_re[ORDER[i]], cur_im[ORDER[i]], i[0], i == N - 1});
            nacc = 0;
        end
    endtask

    task automatic drain(string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || validOut) && n < 300) begin
            step(1);
            n++;
        end
        chk(name, 64'(exp_q.size()), 0);
    endtask

    task automatic monitor();
        logic [2*DW+1:0] got;
        logic [2*DW+1:0] held;
        logic            hold_pend;
        hold_pend = 1'b0;
        held      = '0;
        forever begin
            @(negedge clk);
            cyc++;
            got = {dataReOut, dataImOut, pairSelOut, lastOut};
            if (rst) begin
                hold_pend = 1'b0;
                continue;
            end
            if (hold_pend) begin
                chk("hold_valid", 64'(validOut), 1);
                chk("hold_data", 64'(got), 64'(held));
            end
            hold_pend = 1'b0;
            if (validOut && readyIn) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got %0h expected no output", got);
                end else begin
                    chk("out_data", 64'(got), 64'(exp_q.pop_front()));
                end
                out_cyc.push_back(cyc);
            end else if (validOut) begin
                hold_pend = 1'b1;
                held      = got;
            end
        end
    endtask

    task automatic rdy_toggler();
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy)
                readyIn = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        int start;
        rst      = 1'b1;
        validIn  = 1'b0;
        readyIn  = 1'b0;
        dataReIn = '0;
        dataImIn = '0;
        fork
            monitor();
            rdy_toggler();
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_readyOut", 64'(readyOut), 0);
        chk("rst_validOut", 64'(validOut), 0);
        chk("rst_dataRe", 64'(dataReOut), 0);
        chk("rst_dataIm", 64'(dataImOut), 0);
        chk("rst_pairSel", 64'(pairSelOut), 0);
        chk("rst_last", 64'(lastOut), 0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        readyIn = 1'b1;

        // Single frame and first-output latency
        for (int i = 0; i < N; i++)
            send(DW'(i), DW'(100 + i));
        validIn = 1'b0;
        chk("latency_early", 64'(validOut), 0);
        step(1);
        chk("latency_valid", 64'(validOut), 1);
        chk("latency_x0", 64'(dataReOut), 0);
        drain("drain_single");

        // Continuous streaming, four frames
        stalls = 0;
        start  = out_cyc.size();
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < N; i++)
                send(DW'(16 * f + i), DW'(1000 + 16 * f + i));
        validIn = 1'b0;
        chk("stream_stalls", 64'(stalls), 0);
        drain("drain_stream");
        chk("stream_count", 64'(out_cyc.size() - start), 32);
        if (out_cyc.size() >= start + 32)
            chk("stream_gapless", 64'(out_cyc[start + 31] - out_cyc[start]), 31);

        // Output backpressure with both banks filled
        readyIn = 1'b0;
        for (int i = 0; i < 2 * N; i++)
            send(DW'(200 + i), DW'(16'h8000 + i));
        validIn = 1'b0;
        chk("bp_ready_low", 64'(readyOut), 0);
        chk("bp_valid_held", 64'(validOut), 1);
        step(20);
        chk("bp_ready_still_low", 64'(readyOut), 0);
        chk("bp_head_x0", 64'(dataReOut), 200);
        readyIn = 1'b1;
        drain("drain_bp");
        chk("bp_ready_back", 64'(readyOut), 1);

        // Sparse input with random downstream readiness
        rnd_rdy = 1'b1;
        for (int i = 0; i < 3 * N; i++) begin
            send(DW'(500 + i), DW'($urandom_range(0, 65535)));
            validIn = 1'b0;
            step($urandom_range(0, 2));
        end
        rnd_rdy = 1'b0;
        step(1);
        readyIn = 1'b1;
        drain("drain_sparse");

        // Reset after a partial frame
        for (int i = 0; i < 5; i++)
            send(DW'(300 + i), DW'(300 + i));
        validIn = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        nacc = 0;
        @(negedge clk);
        chk("rst_mid_ready", 64'(readyOut), 0);
        chk("rst_mid_valid", 64'(validOut), 0);
        step(2);
        rst = 1'b0;

        // Reset while emitting
        start = out_cyc.size();
        for (int i = 0; i < N; i++)
            send(DW'(600 + i), DW'(600 + i));
        validIn = 1'b0;
        for (int n = 0; n < 50 && out_cyc.size() < start + 3; n++)
            step(1);
        chk("emit_before_rst", 64'(out_cyc.size() >= start + 3), 1);
        rst = 1'b1;
        exp_q.delete();
        nacc = 0;
        step(1);
        @(negedge clk);
        chk("rst_emit_valid", 64'(validOut), 0);
        chk("rst_emit_ready", 64'(readyOut), 0);
        chk("rst_emit_data", 64'(dataReOut), 0);
        step(1);
        rst = 1'b0;

        // Fresh random frame after reset: no stale samples may leak out
        for (int i = 0; i < N; i++)
            send(DW'(400 + i), DW'($urandom_range(0, 65535)));
        validIn = 1'b0;
        drain("drain_after_rst");

        chk("final_queue_empty", 64'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
